// File: rtl/vec3_length_seq_pkg.sv
// Shared types and constants for the sequential vec3 length unit.
package vec3_length_seq_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned FRAC_BITS  = 16;
  localparam int unsigned ACC_WIDTH  = 2 * DATA_WIDTH;
  localparam int unsigned ROOT_WIDTH = DATA_WIDTH + 1;
  localparam int unsigned SQRT_ITERS = ACC_WIDTH / 2;
  localparam int unsigned CNT_WIDTH  = $clog2(SQRT_ITERS);

  // Largest representable positive Q16.16 value, used when the root saturates.
  localparam logic [DATA_WIDTH-1:0] LEN_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef logic [DATA_WIDTH-1:0] fp_t;

  // x occupies the least-significant component slot.
  typedef struct packed {
    fp_t z;
    fp_t y;
    fp_t x;
  } vec3_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQ_X,
    ST_SQ_Y,
    ST_SQ_Z,
    ST_SQRT,
    ST_DONE
  } len_state_t;

  // Map the guarded root onto {ovf, len}, saturating anything at or above 2^31.
  function automatic logic [DATA_WIDTH:0] sat_len(input logic [ROOT_WIDTH-1:0] root);
    if (root[ROOT_WIDTH-1] || root[ROOT_WIDTH-2]) begin
      return {1'b1, LEN_MAX};
    end
    return {1'b0, root[DATA_WIDTH-1:0]};
  endfunction

endpackage

// File: rtl/vec3_length_seq_isqrt64_serial.sv
// Bit-serial restoring square root: 64-bit radicand, two bits per cycle, floor root.
module isqrt64_serial
  import vec3_length_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ACC_WIDTH-1:0]  radicand,
  output logic                  busy,
  output logic                  done,
  output logic [ROOT_WIDTH-1:0] root
);

  localparam int unsigned REM_WIDTH = DATA_WIDTH + 1;
  localparam int unsigned TRY_WIDTH = REM_WIDTH + 2;

  logic [ACC_WIDTH-1:0]  rad_q;
  logic [REM_WIDTH-1:0]  rem_q;
  logic [ROOT_WIDTH-1:0] root_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic [TRY_WIDTH-1:0]  rem_sh_c;
  logic [TRY_WIDTH-1:0]  trial_c;
  logic [TRY_WIDTH-1:0]  rem_nx_c;
  logic                  ge_c;

  // One restoring step: bring down two radicand bits and try subtracting 4*root+1.
  always_comb begin
    rem_sh_c = {rem_q, rad_q[ACC_WIDTH-1 -: 2]};
    trial_c  = {1'b0, root_q[DATA_WIDTH-1:0], 2'b01};
    ge_c     = (rem_sh_c >= trial_c);
    rem_nx_c = ge_c ? (rem_sh_c - trial_c) : rem_sh_c;
  end

  // Iteration state; done pulses for one cycle after the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (start && !busy) begin
      rad_q  <= radicand;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CNT_WIDTH'(SQRT_ITERS - 1);
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (busy) begin
      rad_q  <= {rad_q[ACC_WIDTH-3:0], 2'b00};
      rem_q  <= REM_WIDTH'(rem_nx_c);
      root_q <= {root_q[DATA_WIDTH-1:0], ge_c};
      if (cnt_q == '0) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign root = root_q;

endmodule

// File: rtl/vec3_length_seq.sv
// Sequential Euclidean length of a signed Q16.16 vec3 with one shared squarer.
module vec3_length_seq
  import vec3_length_seq_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3*DATA_WIDTH-1:0] in_vec,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_len,
  output logic                    out_ovf,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  len_state_t            state;
  vec3_t                 vec_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [ACC_WIDTH-1:0]  acc_q;

  fp_t                   comp_c;
  logic [ACC_WIDTH-1:0]  comp_ext_c;
  logic [ACC_WIDTH-1:0]  sq_c;
  logic [ACC_WIDTH-1:0]  sum_c;
  logic                  sq_start_c;

  logic                  sq_busy;
  logic                  sq_done;
  logic [ROOT_WIDTH-1:0] sq_root;
  logic [DATA_WIDTH:0]   sat_c;

  // Shared squarer: the sign-extended low 64 product bits equal the exact square.
  always_comb begin
    comp_c = vec_q.z;
    case (state)
      ST_SQ_X: comp_c = vec_q.x;
      ST_SQ_Y: comp_c = vec_q.y;
      default: comp_c = vec_q.z;
    endcase
    comp_ext_c = {{DATA_WIDTH{comp_c[DATA_WIDTH-1]}}, comp_c};
    sq_c       = comp_ext_c * comp_ext_c;
    sum_c      = acc_q + sq_c;
    sq_start_c = (state == ST_SQ_Z) && !sq_busy;
    sat_c      = sat_len(sq_root);
  end

  // The root engine takes the complete sum directly while z^2 is being added.
  isqrt64_serial u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sq_start_c),
    .radicand (sum_c),
    .busy     (sq_busy),
    .done     (sq_done),
    .root     (sq_root)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_len   <= '0;
      out_ovf   <= 1'b0;
      out_tag   <= '0;
      vec_q     <= '0;
      tag_q     <= '0;
      acc_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            vec_q    <= vec3_t'(in_vec);
            tag_q    <= in_tag;
            acc_q    <= '0;
            in_ready <= 1'b0;
            state    <= ST_SQ_X;
          end
        end
        ST_SQ_X: begin
          acc_q <= sum_c;
          state <= ST_SQ_Y;
        end
        ST_SQ_Y: begin
          acc_q <= sum_c;
          state <= ST_SQ_Z;
        end
        ST_SQ_Z: begin
          acc_q <= sum_c;
          state <= ST_SQRT;
        end
        ST_SQRT: begin
          if (sq_done) begin
            out_ovf   <= sat_c[DATA_WIDTH];
            out_len   <= sat_c[DATA_WIDTH-1:0];
            out_tag   <= tag_q;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec3_length_seq.sv
// Directed and randomized bench for vec3_length_seq against an arithmetic model.
module tb_vec3_length_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_vec;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_len;
  logic        out_ovf;
  logic [7:0]  out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec3_length_seq #(.TAG_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_len   (out_len),
    .out_ovf   (out_ovf),
    .out_tag   (out_tag)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // floor(sqrt(x^2+y^2+z^2)) in Q16.16 units, saturated at 0x7FFF_FFFF; returns {ovf, len}.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    logic [63:0]  s;
    longint       a;
    logic [31:0]  r;
    logic [31:0]  cand;
    s = 64'd0;
    a = longint'(signed'(x)); s = s + 64'(a * a);
    a = longint'(signed'(y)); s = s + 64'(a * a);
    a = longint'(signed'(z)); s = s + 64'(a * a);
    r = 32'd0;
    for (int b = 31; b >= 0; b--) begin
      cand = r | (32'd1 << b);
      if ((128'(cand) * 128'(cand)) <= 128'(s)) r = cand;
    end
    if (r >= 32'h8000_0000) return {1'b1, 32'h7FFF_FFFF};
    return {1'b0, r};
  endfunction

  // Push one vector, wait for the result, optionally stall, then consume it.
  task automatic run_vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input logic [7:0] tag, input int stall, input bit chk_lat,
                         input bit inject);
    logic [32:0] exp;
    int w;
    int lat;
    exp = model(x, y, z);
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_vec   = {z, y, x};
    in_tag   = tag;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = inject;
    in_vec   = {$urandom(), $urandom(), $urandom()};
    in_tag   = ~tag;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (inject && lat == 20) check("busy_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check("out_valid_seen", 64'(out_valid), 64'd1);
    if (chk_lat) check("latency", 64'(lat), 64'd36);
    check("out_len", 64'(out_len), 64'(exp[31:0]));
    check("out_ovf", 64'(out_ovf), 64'(exp[32]));
    check("out_tag", 64'(out_tag), 64'(tag));
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk); #1;
      end
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_len", 64'(out_len), 64'(exp[31:0]));
      check("hold_ovf", 64'(out_ovf), 64'(exp[32]));
      check("hold_tag", 64'(out_tag), 64'(tag));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] rv [3];
    int sh;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_len", 64'(out_len), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    run_vec(32'h0003_0000, 32'h0004_0000, 32'h0, 8'h5A, 0, 1'b1, 1'b0);
    check("d345_len", 64'(out_len), 64'h0005_0000);
    check("d345_tag", 64'(out_tag), 64'h5A);
    run_vec(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 8'h01, 0, 1'b1, 1'b0);
    check("dsqrt3_len", 64'(out_len), 64'h0001_BB67);
    run_vec(-32'sh0003_0000, 32'h0, -32'sh0004_0000, 8'h02, 1, 1'b1, 1'b0);
    check("dneg_len", 64'(out_len), 64'h0005_0000);
    run_vec(32'h0, 32'h0, 32'h0, 8'h03, 0, 1'b1, 1'b0);
    check("dzero_len", 64'(out_len), 64'h0);
    check("dzero_ovf", 64'(out_ovf), 64'h0);
    run_vec(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 8'h04, 0, 1'b1, 1'b0);
    check("dmax_len", 64'(out_len), 64'h7FFF_FFFF);
    check("dmax_ovf", 64'(out_ovf), 64'h1);
    run_vec(32'h8000_0000, 32'h0, 32'h0, 8'h05, 0, 1'b1, 1'b0);
    check("dmin_len", 64'(out_len), 64'h7FFF_FFFF);
    check("dmin_ovf", 64'(out_ovf), 64'h1);

    // Long back-pressure with traffic presented while busy.
    run_vec(32'h0003_0000, 32'h0004_0000, 32'h0, 8'hC3, 20, 1'b1, 1'b1);
    check("bp_len", 64'(out_len), 64'h0005_0000);
    @(posedge clk); #1;
    check("bp_stays_idle", 64'(in_ready), 64'd1);

    // Reset while the root is mid-iteration.
    in_vec   = {32'h0, 32'h0004_0000, 32'h0003_0000};
    in_tag   = 8'h77;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_len", 64'(out_len), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_output", 64'(out_valid), 64'd0);
    run_vec(32'h0003_0000, 32'h0004_0000, 32'h0, 8'h78, 0, 1'b1, 1'b0);
    check("post_abort_len", 64'(out_len), 64'h0005_0000);

    // Randomized vectors with random stalls; tags follow the issue order.
    for (int i = 0; i < 200; i++) begin
      for (int c = 0; c < 3; c++) begin
        rv[c] = $urandom();
        if ($urandom_range(0, 3) != 0) begin
          sh = $urandom_range(4, 24);
          rv[c] = 32'($signed(rv[c]) >>> sh);
        end
      end
      run_vec(rv[0], rv[1], rv[2], 8'(i), $urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
